// File: rtl/steady_state_pkg.sv
// Shared types and constants for the steady-state AXI4-Lite register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus widths, register indices, response code, FSM state enums,
// and the byte-strobe merge helper used on every register write.
package steady_state_pkg;

  localparam int C_S_AXI_DATA_WIDTH = 32;
  localparam int C_S_AXI_ADDR_WIDTH = 4;
  localparam int STRB_W             = C_S_AXI_DATA_WIDTH / 8;
  localparam int NUM_REGS           = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_THRESH = 2'd1;
  localparam logic [1:0] REG_WINDOW = 2'd2;
  localparam logic [1:0] REG_AUX    = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Merge wdata into old byte-by-byte; bytes with a clear strobe keep old.
  function automatic logic [C_S_AXI_DATA_WIDTH-1:0] apply_wstrb(
    input logic [C_S_AXI_DATA_WIDTH-1:0] old,
    input logic [C_S_AXI_DATA_WIDTH-1:0] wdata,
    input logic [STRB_W-1:0]             wstrb
  );
    logic [C_S_AXI_DATA_WIDTH-1:0] res;
    res = old;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/steady_state_axil_regs_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the register bank.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on all five channels.
// Ports: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready). The slave modport is the register bank.
interface steady_state_axil_regs_if;
  import steady_state_pkg::*;

  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr;
  logic [2:0]                    s00_axi_awprot;
  logic                          s00_axi_awvalid;
  logic                          s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata;
  logic [STRB_W-1:0]             s00_axi_wstrb;
  logic                          s00_axi_wvalid;
  logic                          s00_axi_wready;
  logic [1:0]                    s00_axi_bresp;
  logic                          s00_axi_bvalid;
  logic                          s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr;
  logic [2:0]                    s00_axi_arprot;
  logic                          s00_axi_arvalid;
  logic                          s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata;
  logic [1:0]                    s00_axi_rresp;
  logic                          s00_axi_rvalid;
  logic                          s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );

endinterface

// File: rtl/steady_state_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control words for the steady-state core.
// Latency: AW+W (or AR) valid at edge k -> ready in cycle k+1 -> reg/rdata update at edge k+1.
// Backpressure: one outstanding write and one outstanding read; B/R held until bready/rready.
// Ports: s00_axi_aclk/s00_axi_aresetn (clock, async active-low reset), s_axi (AXI4-Lite
// slave modport), reg0_o..reg3_o (live register contents), reg_wr_stb_o (one-hot,
// one-cycle pulse after each accepted write, also for wstrb == 0).
module steady_state_axil_regs
  import steady_state_pkg::*;
(
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  steady_state_axil_regs_if.slave       s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  output logic [NUM_REGS-1:0]           reg_wr_stb_o
);

  wr_state_t                     r_wr_state, w_wr_state_nxt;
  rd_state_t                     r_rd_state, w_rd_state_nxt;
  logic                          r_aw_w_rdy;
  logic                          r_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [NUM_REGS-1:0]           r_wr_stb;

  logic       w_wr_hs;
  logic       w_rd_hs;
  logic [1:0] w_wr_idx;
  logic [1:0] w_rd_idx;
  logic       w_bvalid;
  logic       w_rvalid;

  // Byte-offset bits and protection fields carry no meaning for this bank.
  logic w_unused;
  assign w_unused = &{1'b0, s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                      s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};

  assign w_wr_idx = s_axi.s00_axi_awaddr[3:2];
  assign w_rd_idx = s_axi.s00_axi_araddr[3:2];

  // Ready is raised only after both AW and W were seen together, so the
  // handshake edge is the one where the registered ready is high.
  assign w_wr_hs = r_aw_w_rdy & s_axi.s00_axi_awvalid & s_axi.s00_axi_wvalid;
  assign w_rd_hs = r_arready & s_axi.s00_axi_arvalid;

  // Write FSM next state
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_bvalid       = 1'b0;
    case (r_wr_state)
      WR_IDLE: if (w_wr_hs) w_wr_state_nxt = WR_RESP;
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.s00_axi_bready) w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rvalid       = 1'b0;
    case (r_rd_state)
      RD_IDLE: if (w_rd_hs) w_rd_state_nxt = RD_DATA;
      RD_DATA: begin
        w_rvalid = 1'b1;
        if (s_axi.s00_axi_rready) w_rd_state_nxt = RD_IDLE;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_wr_state <= WR_IDLE;
      r_rd_state <= RD_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Write path: ready pulse, register update and strobe
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_aw_w_rdy <= 1'b0;
      r_wr_stb   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      // One-cycle pulse; the !r_aw_w_rdy term stops it re-arming while the
      // handshake itself is in progress.
      r_aw_w_rdy <= (r_wr_state == WR_IDLE) & ~r_aw_w_rdy &
                    s_axi.s00_axi_awvalid & s_axi.s00_axi_wvalid;
      r_wr_stb   <= '0;
      if (w_wr_hs) begin
        r_regs[w_wr_idx]   <= apply_wstrb(r_regs[w_wr_idx], s_axi.s00_axi_wdata,
                                          s_axi.s00_axi_wstrb);
        r_wr_stb[w_wr_idx] <= 1'b1;
      end
    end
  end

  // Read path: the capture uses the pre-edge register value, so a same-edge
  // write to the same word is not visible in this read.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= (r_rd_state == RD_IDLE) & ~r_arready & s_axi.s00_axi_arvalid;
      if (w_rd_hs) r_rdata <= r_regs[w_rd_idx];
    end
  end

  assign s_axi.s00_axi_awready = r_aw_w_rdy;
  assign s_axi.s00_axi_wready  = r_aw_w_rdy;
  assign s_axi.s00_axi_bvalid  = w_bvalid;
  assign s_axi.s00_axi_bresp   = RESP_OKAY;
  assign s_axi.s00_axi_arready = r_arready;
  assign s_axi.s00_axi_rvalid  = w_rvalid;
  assign s_axi.s00_axi_rdata   = r_rdata;
  assign s_axi.s00_axi_rresp   = RESP_OKAY;

  assign reg0_o       = r_regs[REG_CTRL];
  assign reg1_o       = r_regs[REG_THRESH];
  assign reg2_o       = r_regs[REG_WINDOW];
  assign reg3_o       = r_regs[REG_AUX];
  assign reg_wr_stb_o = r_wr_stb;

endmodule

// File: tb/tb_steady_state_axil_regs.sv
// Directed bench for the steady-state AXI4-Lite register bank.
// Latency: n/a.
// Backpressure: bench drives bready/rready explicitly per scenario.
module tb_steady_state_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_stb;

  int checks = 0;
  int errors = 0;

  steady_state_axil_regs_if axi ();

  steady_state_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s_axi           (axi.slave),
    .reg0_o          (reg0),
    .reg1_o          (reg1),
    .reg2_o          (reg2),
    .reg3_o          (reg3),
    .reg_wr_stb_o    (wr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: full write, bready held high. Caller is at posedge+1.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic ok,
                          output logic [3:0] stb, output logic [1:0] resp);
    axi.s00_axi_awaddr  = addr;
    axi.s00_axi_wdata   = data;
    axi.s00_axi_wstrb   = strb;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    axi.s00_axi_bready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_awready && axi.s00_axi_wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    stb  = wr_stb;
    resp = axi.s00_axi_bresp;
    ok   = ok & axi.s00_axi_bvalid;
    @(posedge clk); #1;
  endtask

  // Stimulus only: full read, rready held high. Caller is at posedge+1.
  task automatic do_read(input logic [3:0] addr, output logic ok,
                         output logic [31:0] data, output logic [1:0] resp);
    axi.s00_axi_araddr  = addr;
    axi.s00_axi_arvalid = 1'b1;
    axi.s00_axi_rready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axi.s00_axi_arvalid = 1'b0;
    data = axi.s00_axi_rdata;
    resp = axi.s00_axi_rresp;
    ok   = ok & axi.s00_axi_rvalid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axi.s00_axi_awaddr = '0; axi.s00_axi_awprot = '0; axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wdata  = '0; axi.s00_axi_wstrb  = '0; axi.s00_axi_wvalid  = 1'b0;
    axi.s00_axi_bready = 1'b1;
    axi.s00_axi_araddr = '0; axi.s00_axi_arprot = '0; axi.s00_axi_arvalid = 1'b0;
    axi.s00_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_bvalid,
         axi.s00_axi_arready, axi.s00_axi_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got aw/w/b/ar/r=%b, expected 00000",
               {axi.s00_axi_awready, axi.s00_axi_wready, axi.s00_axi_bvalid,
                axi.s00_axi_arready, axi.s00_axi_rvalid});
    end
    checks++;
    if ({reg0, reg1, reg2, reg3} !== 128'h0 || wr_stb !== 4'h0 || axi.s00_axi_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got r0=%h r1=%h r2=%h r3=%h stb=%b rdata=%h, expected all 0",
               reg0, reg1, reg2, reg3, wr_stb, axi.s00_axi_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi.s00_axi_awready !== 1'b0 || axi.s00_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got awready=%b bvalid=%b, expected 0 0",
               axi.s00_axi_awready, axi.s00_axi_bvalid);
    end
  endtask

  task automatic test_seq_write_read();
    logic        ok;
    logic [3:0]  stb;
    logic [1:0]  resp;
    logic [31:0] data;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), 32'(i + 1), 4'hF, ok, stb, resp);
      checks++;
      if (ok !== 1'b1 || stb !== 4'(1 << i) || resp !== 2'b00) begin
        errors++;
        $display("FAIL seq_write[%0d]: got ok=%b stb=%b bresp=%b, expected ok=1 stb=%b bresp=00",
                 i, ok, stb, resp, 4'(1 << i));
      end
    end
    checks++;
    if (wr_stb !== 4'h0) begin
      errors++;
      $display("FAIL stb_width: got stb=%b after B, expected 0000", wr_stb);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), ok, data, resp);
      checks++;
      if (ok !== 1'b1 || data !== 32'(i + 1) || resp !== 2'b00) begin
        errors++;
        $display("FAIL seq_read[%0d]: got ok=%b rdata=%h rresp=%b, expected ok=1 rdata=%h rresp=00",
                 i, ok, data, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic        ok;
    logic [3:0]  stb;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(4'h4, 32'hAABBCCDD, 4'hF, ok, stb, resp);
    do_write(4'h4, 32'h11223344, 4'b0101, ok, stb, resp);
    do_read(4'h4, ok, data, resp);
    checks++;
    if (ok !== 1'b1 || data !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL partial_strobe: got ok=%b rdata=%h, expected ok=1 rdata=aa22cc44", ok, data);
    end
    // wstrb == 0 still completes and still strobes
    do_write(4'hC, 32'hDEADBEEF, 4'h0, ok, stb, resp);
    checks++;
    if (ok !== 1'b1 || stb !== 4'b1000 || reg3 !== 32'h4) begin
      errors++;
      $display("FAIL zero_strobe: got ok=%b stb=%b reg3=%h, expected ok=1 stb=1000 reg3=00000004",
               ok, stb, reg3);
    end
    // low address bits are ignored on both channels
    do_write(4'h9, 32'h12345678, 4'hF, ok, stb, resp);
    do_read(4'hB, ok, data, resp);
    checks++;
    if (ok !== 1'b1 || data !== 32'h12345678 || reg2 !== 32'h12345678) begin
      errors++;
      $display("FAIL addr_alias: got rdata=%h reg2=%h, expected 12345678 12345678", data, reg2);
    end
  endtask

  task automatic test_aw_only();
    logic seen;
    int   bcount;
    int   bfirst;
    axi.s00_axi_awaddr  = 4'h0;
    axi.s00_axi_wdata   = 32'h0000000A;
    axi.s00_axi_wstrb   = 4'hF;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b0;
    axi.s00_axi_bready  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_awready || axi.s00_axi_wready || axi.s00_axi_bvalid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL aw_only: got early ready/bvalid=%b, expected 0", seen);
    end
    axi.s00_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi.s00_axi_awready !== 1'b1 || axi.s00_axi_wready !== 1'b1) begin
      errors++;
      $display("FAIL aw_w_ready: got awready=%b wready=%b, expected 1 1",
               axi.s00_axi_awready, axi.s00_axi_wready);
    end
    bcount = 0;
    bfirst = -1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_bvalid === 1'b1) begin
        bcount++;
        if (bfirst < 0) bfirst = i;
      end
      if (i == 0) begin
        axi.s00_axi_awvalid = 1'b0;
        axi.s00_axi_wvalid  = 1'b0;
      end
    end
    checks++;
    if (bcount != 1 || bfirst != 0 || reg0 !== 32'h0000000A) begin
      errors++;
      $display("FAIL single_b: got bcount=%0d first=%0d reg0=%h, expected 1 0 0000000a",
               bcount, bfirst, reg0);
    end
  endtask

  task automatic test_bready_hold();
    logic ok;
    logic bad;
    axi.s00_axi_awaddr  = 4'h0;
    axi.s00_axi_wdata   = 32'h77;
    axi.s00_axi_wstrb   = 4'hF;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    axi.s00_axi_bready  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    // queue the second write immediately behind the first
    axi.s00_axi_awaddr = 4'h4;
    axi.s00_axi_wdata  = 32'h88;
    checks++;
    if (ok !== 1'b1 || axi.s00_axi_bvalid !== 1'b1) begin
      errors++;
      $display("FAIL first_write: got ok=%b bvalid=%b, expected 1 1", ok, axi.s00_axi_bvalid);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_bvalid !== 1'b1 || axi.s00_axi_awready !== 1'b0 ||
          axi.s00_axi_wready !== 1'b0 || reg1 !== 32'hAA22CC44) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bready_hold: got violation=%b, expected 0 (bvalid held, no accept, reg1 kept)", bad);
    end
    axi.s00_axi_bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    checks++;
    if (ok !== 1'b1 || axi.s00_axi_bvalid !== 1'b1 || reg0 !== 32'h77 || reg1 !== 32'h88) begin
      errors++;
      $display("FAIL second_write: got ok=%b bvalid=%b reg0=%h reg1=%h, expected 1 1 00000077 00000088",
               ok, axi.s00_axi_bvalid, reg0, reg1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_hold_concurrent();
    logic bad;
    axi.s00_axi_araddr  = 4'h4;
    axi.s00_axi_arvalid = 1'b1;
    axi.s00_axi_rready  = 1'b0;
    axi.s00_axi_awaddr  = 4'h4;
    axi.s00_axi_wdata   = 32'h99;
    axi.s00_axi_wstrb   = 4'hF;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    axi.s00_axi_bready  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi.s00_axi_arready !== 1'b1 || axi.s00_axi_awready !== 1'b1) begin
      errors++;
      $display("FAIL concurrent_ready: got arready=%b awready=%b, expected 1 1",
               axi.s00_axi_arready, axi.s00_axi_awready);
    end
    @(posedge clk); #1;
    axi.s00_axi_arvalid = 1'b0;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    checks++;
    if (axi.s00_axi_rvalid !== 1'b1 || axi.s00_axi_rdata !== 32'h88 || reg1 !== 32'h99) begin
      errors++;
      $display("FAIL read_old_value: got rvalid=%b rdata=%h reg1=%h, expected 1 00000088 00000099",
               axi.s00_axi_rvalid, axi.s00_axi_rdata, reg1);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_rvalid !== 1'b1 || axi.s00_axi_rdata !== 32'h88) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL rready_hold: got violation=%b, expected 0 (rvalid/rdata stable)", bad);
    end
    axi.s00_axi_rready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi.s00_axi_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_release: got rvalid=%b, expected 0", axi.s00_axi_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic        ok;
    logic [3:0]  stb;
    logic [1:0]  resp;
    logic [31:0] data;
    do_write(4'h8, 32'h5, 4'hF, ok, stb, resp);
    checks++;
    if (ok !== 1'b1 || reg2 !== 32'h5) begin
      errors++;
      $display("FAIL write5: got ok=%b reg2=%h, expected 1 00000005", ok, reg2);
    end
    axi.s00_axi_araddr  = 4'h8;
    axi.s00_axi_arvalid = 1'b1;
    axi.s00_axi_rready  = 1'b0;
    axi.s00_axi_awaddr  = 4'h0;
    axi.s00_axi_wdata   = 32'h55;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    axi.s00_axi_bready  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (axi.s00_axi_rvalid && axi.s00_axi_bvalid) break;
    end
    axi.s00_axi_arvalid = 1'b0;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    checks++;
    if (axi.s00_axi_rvalid !== 1'b1 || axi.s00_axi_bvalid !== 1'b1 || axi.s00_axi_rdata !== 32'h5) begin
      errors++;
      $display("FAIL pending_resp: got rvalid=%b bvalid=%b rdata=%h, expected 1 1 00000005",
               axi.s00_axi_rvalid, axi.s00_axi_bvalid, axi.s00_axi_rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (axi.s00_axi_rvalid !== 1'b0 || axi.s00_axi_bvalid !== 1'b0 || reg2 !== 32'h0 ||
        reg0 !== 32'h0 || axi.s00_axi_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got rvalid=%b bvalid=%b reg0=%h reg2=%h rdata=%h, expected 0 0 0 0 0",
               axi.s00_axi_rvalid, axi.s00_axi_bvalid, reg0, reg2, axi.s00_axi_rdata);
    end
    axi.s00_axi_rready = 1'b1;
    axi.s00_axi_bready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (axi.s00_axi_rvalid !== 1'b0 || axi.s00_axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL resp_discarded: got rvalid=%b bvalid=%b, expected 0 0",
               axi.s00_axi_rvalid, axi.s00_axi_bvalid);
    end
    do_read(4'h8, ok, data, resp);
    checks++;
    if (ok !== 1'b1 || data !== 32'h0) begin
      errors++;
      $display("FAIL read_after_reset: got ok=%b rdata=%h, expected 1 00000000", ok, data);
    end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_strobe();
    test_aw_only();
    test_bready_hold();
    test_read_hold_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
